// File: rtl/gen_pacer_pkg.sv
// Shared types and constants for the generation pacer: FSM encoding, BCD digit type,
// default divider/debounce values and the packed-BCD increment helper.
package gen_pacer_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED    = 2'd0,
        ST_RUN       = 2'd1,
        ST_BUSY_RUN  = 2'd2,
        ST_BUSY_STEP = 2'd3
    } pacer_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  BCD_MAX_DIGIT        = 4'd9;
    localparam int          BCD_DIGITS           = 4;
    localparam int unsigned DEF_DIV_SLOW         = 50_000_000;
    localparam int unsigned DEF_DIV_FAST         = 5_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1_000_000;

    // Returns {carry_out, value + 1}. Digits at or above 9 roll to 0, so a corrupted
    // digit is pulled back into legal BCD on the next increment.
    function automatic logic [16:0] bcd_increment(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        bcd_digit_t  digit;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            digit = value[i*4 +: 4];
            if (carry) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    result[i*4 +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[i*4 +: 4] = digit + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return {carry, result};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-sample debouncer and a one-cycle
// press pulse on each rising edge of the accepted level.
module btn_debounce
    import gen_pacer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The down-counter runs only while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            level_d = sync_q[1];
            cnt_d   = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= RELOAD;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/generation_pacer.sv
// Run-control FSM, step-rate timer and 4-digit BCD generation counter for the Life engine.
// Build option GEN_COUNT_SATURATE_EN: counter holds at 9999 and gen_wrap stays low.
module generation_pacer
    import gen_pacer_pkg::*;
#(
    parameter int unsigned DIV_SLOW        = DEF_DIV_SLOW,
    parameter int unsigned DIV_FAST        = DEF_DIV_FAST,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        fast,
    input  logic        step_done,
    output logic        step_req,
    output logic        running,
    output logic [15:0] displayed_number,
    output logic        gen_wrap
);

    localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int          TW      = $clog2(DIV_MAX + 1);

    pacer_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, reload_val;
    logic          pause_pending_q, pause_pending_d;
    logic [15:0]   count_q, count_d;
    logic          gen_wrap_q, gen_wrap_d;
    logic          step_req_q, step_req_d;
    logic          running_q, running_d;
    logic [1:0]    fast_sync_q;

    logic          run_press, step_press;
    logic          done_acc;
    logic [15:0]   inc_value;
    logic          inc_carry;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_i   (btn_run),
        .press_o (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_i   (btn_step),
        .press_o (step_press)
    );

    // The rate is only sampled here, at load/reload, so a change never cuts a count short.
    assign reload_val = fast_sync_q[1] ? TW'(DIV_FAST) : TW'(DIV_SLOW);
    assign done_acc   = step_req_q & step_done;
    assign {inc_carry, inc_value} = bcd_increment(count_q);

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        pause_pending_d = pause_pending_q;
        unique case (state_q)
            ST_PAUSED: begin
                if (run_press) begin
                    state_d = ST_RUN;
                    timer_d = reload_val;
                end else if (step_press) begin
                    state_d = ST_BUSY_STEP;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_d = ST_PAUSED;
                end else if (timer_q == '0) begin
                    state_d = ST_BUSY_RUN;
                    timer_d = reload_val;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_BUSY_RUN: begin
                if (done_acc) begin
                    state_d         = (pause_pending_q || run_press) ? ST_PAUSED : ST_RUN;
                    pause_pending_d = 1'b0;
                end else if (run_press) begin
                    pause_pending_d = 1'b1;
                end
            end
            ST_BUSY_STEP: begin
                if (done_acc) begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d         = ST_PAUSED;
                pause_pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d    = count_q;
        gen_wrap_d = 1'b0;
`ifdef GEN_COUNT_SATURATE_EN
        if (done_acc && !inc_carry) begin
            count_d = inc_value;
        end
`else
        if (done_acc) begin
            count_d    = inc_value;
            gen_wrap_d = inc_carry;
        end
`endif
    end

    assign step_req_d = (state_d == ST_BUSY_RUN) || (state_d == ST_BUSY_STEP);
    assign running_d  = (state_d == ST_RUN) || (state_d == ST_BUSY_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_PAUSED;
            timer_q         <= '0;
            pause_pending_q <= 1'b0;
            count_q         <= 16'h0000;
            gen_wrap_q      <= 1'b0;
            step_req_q      <= 1'b0;
            running_q       <= 1'b0;
            fast_sync_q     <= 2'b00;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            pause_pending_q <= pause_pending_d;
            count_q         <= count_d;
            gen_wrap_q      <= gen_wrap_d;
            step_req_q      <= step_req_d;
            running_q       <= running_d;
            fast_sync_q     <= {fast_sync_q[0], fast};
        end
    end

    assign step_req         = step_req_q;
    assign running          = running_q;
    assign displayed_number = count_q;
    assign gen_wrap         = gen_wrap_q;

endmodule

// File: tb/tb_generation_pacer.sv
// Scoreboard bench for generation_pacer: an engine model answers step requests and
// queues the expected counter value; a monitor pops and compares on every counter update.
module tb_generation_pacer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_step = 1'b0;
    logic        fast = 1'b0;
    logic        step_done = 1'b0;
    logic        step_req;
    logic        running;
    logic [15:0] displayed_number;
    logic        gen_wrap;

    generation_pacer #(
        .DIV_SLOW        (10),
        .DIV_FAST        (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_run          (btn_run),
        .btn_step         (btn_step),
        .fast             (fast),
        .step_done        (step_done),
        .step_req         (step_req),
        .running          (running),
        .displayed_number (displayed_number),
        .gen_wrap         (gen_wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] num;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   sat_hits = 0;
    int   wrap_cnt = 0;
    logic [15:0] wrap_from = 16'h0;
    logic [15:0] wrap_to = 16'h0;
    bit   engine_en = 1'b0;
    int   done_delay = 2;
    int   done_hold = 1;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: records step_req rising edges and checks every counter update.
    logic [15:0] prev_num = 16'h0;
    logic        prev_req = 1'b0;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (step_req && !prev_req) rise_q.push_back(cyc);
        if (gen_wrap) begin
            wrap_cnt++;
            wrap_from = prev_num;
            wrap_to   = displayed_number;
        end
        if (displayed_number !== prev_num || gen_wrap) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got %h wrap %b, expected no update (cycle %0d)",
                         displayed_number, gen_wrap, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("gen_count", 32'(displayed_number), 32'(mon_e.num));
                check("gen_wrap", 32'(gen_wrap), 32'(mon_e.wrap));
            end
        end
        prev_num = displayed_number;
        prev_req = step_req;
    end

    // Engine model: answers each request done_delay cycles later, holding done_hold cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (engine_en && step_req) begin
                repeat (done_delay - 1) @(posedge clk);
                #1;
                step_done = 1'b1;
`ifdef GEN_COUNT_SATURATE_EN
                if (model_cnt == 9999) begin
                    sat_hits++;
                end else begin
                    model_cnt++;
                    exp_q.push_back('{num: to_bcd(model_cnt), wrap: 1'b0});
                end
`else
                model_cnt = (model_cnt + 1) % 10000;
                exp_q.push_back('{num: to_bcd(model_cnt), wrap: (model_cnt == 0)});
`endif
                repeat (done_hold) @(posedge clk);
                #1;
                step_done = 1'b0;
            end
        end
    end

    task automatic wait_to_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rises(input int n, input int limit, input string name);
        int start;
        start = cyc;
        while (rise_q.size() < n && cyc - start < limit) begin
            @(posedge clk);
            #1;
        end
        if (rise_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d requests, needed %0d", name, rise_q.size(), n);
        end
    endtask

    task automatic press(input bit is_run);
        if (is_run) btn_run = 1'b1;
        else        btn_step = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, r0, r1, r2, r3, r, t0;

        // Reset values
        #2 reset = 1'b0;
        #18;
        check("rst_step_req", 32'(step_req), 0);
        check("rst_running", 32'(running), 0);
        check("rst_number", 32'(displayed_number), 32'h0000);
        check("rst_gen_wrap", 32'(gen_wrap), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Asynchronous reset in the middle of BUSY_RUN
        engine_en = 1'b0;
        n0 = rise_q.size();
        press(1'b1);
        wait_rises(n0 + 1, 40, "busy_req_before_reset");
        check("busy_running", 32'(running), 1);
        check("busy_step_req", 32'(step_req), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_req", 32'(step_req), 0);
        check("async_reset_running", 32'(running), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        n0 = rise_q.size();
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_no_req", 32'(rise_q.size()), 32'(n0));
        check("post_reset_number", 32'(displayed_number), 32'h0000);

        // Single step, engine holds done for 3 cycles
        engine_en  = 1'b1;
        done_delay = 5;
        done_hold  = 3;
        n0 = rise_q.size();
        press(1'b0);
        wait_rises(n0 + 1, 40, "single_step_req");
        r = rise_q[n0];
        wait_to_cyc(r + 30);
        check("single_step_req_count", 32'(rise_q.size()), 32'(n0 + 1));
        check("single_step_number", 32'(displayed_number), 32'h0001);
        check("single_step_running", 32'(running), 0);
        check("single_step_req_low", 32'(step_req), 0);

        // Slow run cadence
        done_delay = 2;
        done_hold  = 1;
        n0 = rise_q.size();
        press(1'b1);
        wait_rises(n0 + 3, 80, "slow_cadence");
        r0 = rise_q[n0];
        r1 = rise_q[n0 + 1];
        r2 = rise_q[n0 + 2];
        check("slow_interval_a", 32'(r1 - r0), 13);
        check("slow_interval_b", 32'(r2 - r1), 13);

        // Run press landing on the timer-expiry cycle: no request, paused
        wait_to_cyc(r2 + 6);
        btn_run = 1'b1;
        wait_to_cyc(r2 + 12);
        btn_run = 1'b0;
        wait_to_cyc(r2 + 45);
        check("simul_expiry_no_req", 32'(rise_q.size()), 32'(n0 + 3));
        check("simul_expiry_running", 32'(running), 0);

        // Run press during BUSY_RUN: handshake completes, then paused
        press(1'b1);
        wait_rises(n0 + 4, 40, "pause_busy_first_req");
        r = rise_q[n0 + 3];
        wait_to_cyc(r + 7);
        btn_run = 1'b1;
        wait_to_cyc(r + 13);
        btn_run = 1'b0;
        wait_to_cyc(r + 14);
        check("pause_busy_req_issued", 32'(rise_q.size()), 32'(n0 + 5));
        check("pause_busy_req_time", 32'(rise_q[n0 + 4]), 32'(r + 13));
        check("pause_busy_still_running", 32'(running), 1);
        wait_to_cyc(r + 17);
        check("pause_busy_running_low", 32'(running), 0);
        check("pause_busy_req_low", 32'(step_req), 0);
        wait_to_cyc(r + 50);
        check("pause_busy_no_more_req", 32'(rise_q.size()), 32'(n0 + 5));

        // Bouncing run button is rejected
        n0 = rise_q.size();
        for (int i = 0; i < 10; i++) begin
            btn_run = ~btn_run;
            repeat (2) @(posedge clk);
            #1;
        end
        btn_run = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bounce_running", 32'(running), 0);
        check("bounce_no_req", 32'(rise_q.size()), 32'(n0));

        // Rate change applies at the next reload only
        n0 = rise_q.size();
        fast = 1'b0;
        press(1'b1);
        wait_rises(n0 + 1, 40, "rate_first_req");
        fast = 1'b1;
        wait_rises(n0 + 4, 80, "rate_fast_reqs");
        r0 = rise_q[n0];
        r1 = rise_q[n0 + 1];
        r2 = rise_q[n0 + 2];
        r3 = rise_q[n0 + 3];
        check("rate_no_mid_count", 32'(r1 - r0), 13);
        check("fast_interval_a", 32'(r2 - r1), 6);
        check("fast_interval_b", 32'(r3 - r2), 6);

        // Keep running fast through the 9999 boundary
        t0 = cyc;
`ifdef GEN_COUNT_SATURATE_EN
        while (sat_hits < 3 && cyc - t0 < 80000) begin
            @(posedge clk);
            #1;
        end
        check("saturate_reached", 32'(sat_hits >= 3), 1);
`else
        while (!(wrap_cnt >= 1 && model_cnt >= 2) && cyc - t0 < 80000) begin
            @(posedge clk);
            #1;
        end
        check("wrap_reached", 32'(wrap_cnt >= 1), 1);
`endif
        press(1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("final_running", 32'(running), 0);
`ifdef GEN_COUNT_SATURATE_EN
        check("saturate_number", 32'(displayed_number), 32'h9999);
        check("saturate_no_wrap", 32'(wrap_cnt), 0);
`else
        check("wrap_pulse_count", 32'(wrap_cnt), 1);
        check("wrap_from", 32'(wrap_from), 32'h9999);
        check("wrap_to", 32'(wrap_to), 32'h0000);
`endif
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/generation_pacer.md
# generation_pacer

Paces the Game of Life engine and supplies the generation count to the seven-segment display stage. Debounced run/pause and single-step buttons drive a run-control FSM. The FSM issues step requests to the engine at a selectable rate, using a req/done handshake. Each completed generation increments a 4-digit packed-BCD counter, which the display logic multiplexes onto the anodes.

## Interface
- `DIV_SLOW`, default 50_000_000: clocks between step requests when `fast`=0 (2 Hz at 100 MHz).
- `DIV_FAST`, default 5_000_000: clocks between step requests when `fast`=1.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-input cycles required before a button level is accepted.
- `clk` in 1: system clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_run` in 1: raw run/pause button; each accepted press toggles run/pause.
- `btn_step` in 1: raw single-step button.
- `fast` in 1: rate select, synchronised internally.
- `step_done` in 1: engine finished the requested generation.
- `step_req` out 1: request one generation; held until done.
- `running` out 1: high in RUN and BUSY_RUN.
- `displayed_number` out 16: packed BCD {thousands, hundreds, tens, ones}.
- `gen_wrap` out 1: one-cycle pulse on the 9999→0000 rollover.

## Operation
- **Buttons:** each button passes through a 2-flop synchroniser and a debouncer. The debounced level is accepted after `DEBOUNCE_CYCLES` consecutive equal samples. A rising edge of the accepted level produces one press pulse.
- **FSM states:** PAUSED (reset state), RUN, BUSY_RUN, BUSY_STEP.
- **PAUSED:**
  - run press → RUN; the rate timer loads the divider for the current `fast` value.
  - step press → BUSY_STEP with `step_req`=1.
- **RUN:**
  - The timer decrements each cycle.
  - At 0: → BUSY_RUN, `step_req`=1, timer reloads.
  - run press → PAUSED.
  - step press is ignored.
- **BUSY_RUN:**
  - The timer is frozen.
  - A run press sets `pause_pending`.
  - On `step_done`: → PAUSED if `pause_pending`, else RUN. `pause_pending` clears on exit.
- **BUSY_STEP:**
  - On `step_done` → PAUSED.
  - All presses are ignored.
- **Handshake:**
  - `step_done` is sampled only while `step_req`=1; `step_done` while `step_req`=0 is ignored.
  - The engine may hold `step_done` for several cycles; only the first sampled cycle counts.
- **Counter:**
  - Increments by 1 on each accepted `step_done`.
  - Each digit is 0–9 with carry into the next digit.
  - 9999 + 1 → 0000, with `gen_wrap`=1 for that cycle.
  - Never leaves legal BCD.
- **Rate change:** a `fast` change takes effect at the next timer reload; it is not applied mid-count.
- **Simultaneous events:**
  - A run press and timer expiry in the same RUN cycle → PAUSED; no request is issued.
  - A run press and `step_done` in the same BUSY_RUN cycle → PAUSED.

## Timing
- Reset values: `step_req`=0, `running`=0, `displayed_number`=16'h0000, `gen_wrap`=0, FSM=PAUSED, timer=0, `pause_pending`=0.
- Reset is asynchronous: asserting `reset` mid-handshake drops `step_req` immediately. The engine is responsible for abandoning the step.
- All outputs are registered.
- Button latency: a press is seen 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) cycles after the raw edge.
- `step_req` rises the cycle after the expiry or press decision.
- `step_done` sampled high at edge N:
  - `step_req`=0, `displayed_number` updated and `gen_wrap` valid after edge N.
  - Earliest next `step_req` in RUN: edge N+`DIV`+1.

## Configuration
- `GEN_COUNT_SATURATE_EN` defined:
  - The counter holds at 9999; further `step_done` events still complete handshakes but do not count.
  - `gen_wrap` is tied 0.
- Undefined: the counter wraps as described in Operation.

## Structure
- Shared package `gen_pacer_pkg`:
  - FSM state encoding.
  - 4-bit BCD digit type and `BCD_MAX_DIGIT`=9.
  - Default divider and debounce constants.
- Sub-module `btn_debounce` holds the synchroniser, stable counter and rising-edge pulse. It is instantiated once per button.
- The FSM, rate timer and BCD counter live in `generation_pacer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `DIV_SLOW`=10, `DIV_FAST`=3.
- **Reset:** assert `reset`=0 mid-BUSY_RUN → `step_req`=0 within the same cycle; after release, outputs are 0 and FSM is PAUSED.
- **Single step:** `btn_step` pulse 6 cycles; engine answers `step_done` 5 cycles after `step_req` → exactly one request; `displayed_number`=16'h0001; FSM returns to PAUSED.
- **Run cadence:** run press, engine done 2 cycles after req, `fast`=0 → `step_req` rising edges 13 cycles apart. With `fast`=1 → 6 cycles apart after the next reload.
- **Pause during busy:** run press in BUSY_RUN → handshake completes, count +1, `running`=0, no further `step_req`.
- **Bounce reject:** `btn_run` toggling every 2 cycles for 20 cycles, then low → no state change.
- **Wrap:** preload to 16'h9999 via steps, one more step → 16'h0000 and a 1-cycle `gen_wrap`. With `GEN_COUNT_SATURATE_EN` defined → stays 16'h9999, `gen_wrap`=0.
